data_mem_stage: RTL and testbench

- Multi-cycle data-memory access stage directly downstream of the ALU in the 32-bit LEGv8-style datapath.
- Takes the ALU result as a byte address and services LDUR (load) and STUR (store) against an internal word-addressed RAM.
- Presents read data to writeback.
- Asserts busy so the control path stalls PC and register writeback until the access completes.

---
 rtl/data_mem_stage.sv | 131 +++++++++++++
 tb/tb_data_mem_stage.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/data_mem_stage.sv
// ----------------------------------------------------------------------------
// data_mem_stage
//   Multi-cycle data-memory access stage that sits after the ALU. It services
//   LDUR (load) and STUR (store) against an internal word-addressed RAM and
//   holds busy high so the control path stalls until the access completes.
//
//   state  | meaning
//   -------+-----------------------------------------------------------------
//   IDLE   | waiting for start with MemRead or MemWrite set
//   ACCESS | valid request in flight, counting down LATENCY wait cycles
//   RESP   | one-cycle completion (done=1); mem_err=1 if the request was rejected
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       request strobe, sampled only in IDLE
//   MemRead     load qualifier
//   MemWrite    store qualifier
//   ALU_Result  byte address
//   Write_data  store data
//   Read_data   load result, held until the next successful load
//   busy        high in ACCESS and RESP
//   done        one-cycle completion pulse
//   mem_err     valid with done; request rejected, no memory effect
// ----------------------------------------------------------------------------
module data_mem_stage #(
   parameter int DEPTH   = 64,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [31:0] ALU_Result,
   input  logic [31:0] Write_data,
   output logic [31:0] Read_data,
   output logic        busy,
   output logic        done,
   output logic        mem_err
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic [AW-1:0] r_idx;
   logic [31:0]   r_wdata;
   logic          r_rd;
   logic          r_wr;
   logic          r_err;
   logic [31:0]   r_rd_data;
   logic [31:0]   r_mem [DEPTH];

   logic          w_req;
   logic          w_err;
   logic          w_commit;

   assign w_req = start && (MemRead || MemWrite);

   // Out-of-range compare is done one bit wider so DEPTH*4 cannot wrap.
   assign w_err = (MemRead && MemWrite) ||
                  (ALU_Result[1:0] != 2'b00) ||
                  ({1'b0, ALU_Result} >= 33'(DEPTH * 4));

   assign w_commit = (r_state == ACCESS) && (r_cnt == '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_idx     <= '0;
         r_wdata   <= '0;
         r_rd      <= 1'b0;
         r_wr      <= 1'b0;
         r_err     <= 1'b0;
         r_rd_data <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_req) begin
                  r_idx   <= ALU_Result[AW+1:2];
                  r_wdata <= Write_data;
                  r_rd    <= MemRead;
                  r_wr    <= MemWrite;
                  r_err   <= w_err;
                  r_cnt   <= CW'(LATENCY - 1);
                  r_state <= w_err ? RESP : ACCESS;
               end
            end
            ACCESS: begin
               if (r_cnt == '0) begin
                  // Stores commit in the RAM block below on this same edge.
                  if (!r_wr && r_rd) begin
                     r_rd_data <= r_mem[r_idx];
                  end
                  r_state <= RESP;
               end else begin
                  r_cnt <= r_cnt - 1'b1;
               end
            end
            RESP: begin
               r_err   <= 1'b0;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // RAM has no reset; contents survive rst_n. A reset before the commit edge
   // forces r_state to IDLE, which aborts the pending store.
   always_ff @(posedge clk) begin
      if (w_commit && r_wr) begin
         r_mem[r_idx] <= r_wdata;
      end
   end

   assign Read_data = r_rd_data;
   assign busy      = (r_state != IDLE);
   assign done      = (r_state == RESP);
   assign mem_err   = (r_state == RESP) && r_err;

endmodule

// File: tb/tb_data_mem_stage.sv
module tb_data_mem_stage;

   localparam int DEPTH   = 64;
   localparam int LATENCY = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        MemRead;
   logic        MemWrite;
   logic [31:0] ALU_Result;
   logic [31:0] Write_data;
   logic [31:0] Read_data;
   logic        busy;
   logic        done;
   logic        mem_err;

   int n_checks = 0;
   int n_errors = 0;

   // reference model: word array + last successful load value
   logic [31:0] m_mem [DEPTH];
   logic [31:0] m_rd;

   data_mem_stage #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .MemRead    (MemRead),
      .MemWrite   (MemWrite),
      .ALU_Result (ALU_Result),
      .Write_data (Write_data),
      .Read_data  (Read_data),
      .busy       (busy),
      .done       (done),
      .mem_err    (mem_err)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Called just after a negedge. Issues one request, follows it to done and
   // one cycle beyond, and returns right after a negedge with the DUT idle.
   // With interfere=1 a conflicting store is presented while the DUT is busy.
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data, input bit interfere,
                         input logic [31:0] i_addr, input logic [31:0] i_data);
      bit          exp_err;
      int          exp_lat;
      int          n;
      logic [31:0] old_rd;
      exp_err = (rd && wr) || (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
      exp_lat = exp_err ? 1 : LATENCY + 1;
      old_rd  = m_rd;
      if (!exp_err) begin
         if (wr) m_mem[addr >> 2] = data;
         else    m_rd = m_mem[addr >> 2];
      end
      start = 1'b1; MemRead = rd; MemWrite = wr; ALU_Result = addr; Write_data = data;
      @(posedge clk);
      @(negedge clk);
      if (interfere) begin
         start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1;
         ALU_Result = i_addr; Write_data = i_data;
      end else begin
         start = 1'b0;
      end
      n = 1;
      while (!done && n < 10) begin
         check_eq("busy_in_flight", 32'(busy), 32'd1);
         check_eq("rd_held_in_flight", Read_data, old_rd);
         @(negedge clk);
         start = 1'b0;
         n++;
      end
      start = 1'b0;
      check_eq("done_latency", n, exp_lat);
      check_eq("busy_at_done", 32'(busy), 32'd1);
      check_eq("mem_err", 32'(mem_err), 32'(exp_err));
      check_eq("read_data", Read_data, m_rd);
      @(negedge clk);
      check_eq("done_single_pulse", 32'(done), 32'd0);
      check_eq("busy_after_resp", 32'(busy), 32'd0);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic        rd;
      logic        wr;
      int          kind;

      rst_n = 1'b0; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
      ALU_Result = '0; Write_data = '0; m_rd = '0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // mid-cycle async reset
      #3 rst_n = 1'b0;
      #1;
      check_eq("rst_busy", 32'(busy), 32'd0);
      check_eq("rst_done", 32'(done), 32'd0);
      check_eq("rst_err", 32'(mem_err), 32'd0);
      check_eq("rst_rdata", Read_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      check_eq("idle_busy", 32'(busy), 32'd0);
      check_eq("idle_done", 32'(done), 32'd0);

      // start with no qualifier is ignored
      start = 1'b1; ALU_Result = 32'h10;
      @(negedge clk);
      start = 1'b0;
      check_eq("no_qual_ignored", 32'(busy), 32'd0);

      // fill RAM with known contents
      for (int i = 0; i < DEPTH; i++) begin
         do_req(1'b0, 1'b1, 32'(i * 4), $urandom, 1'b0, '0, '0);
      end

      // store then load
      do_req(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, '0, '0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, '0, '0);

      // error cases: Read_data and RAM must be unaffected
      do_req(1'b1, 1'b0, 32'h12, 32'h0, 1'b0, '0, '0);
      do_req(1'b1, 1'b0, 32'h100, 32'h0, 1'b0, '0, '0);
      do_req(1'b1, 1'b1, 32'h10, 32'h12345678, 1'b0, '0, '0);
      do_req(1'b0, 1'b1, 32'h16, 32'hBAD0BAD0, 1'b0, '0, '0);
      do_req(1'b1, 1'b0, 32'h14, 32'h0, 1'b0, '0, '0);
      do_req(1'b1, 1'b0, 32'h10, 32'h0, 1'b0, '0, '0);

      // start while busy must not be queued
      do_req(1'b0, 1'b1, 32'h30, 32'hA5A5A5A5, 1'b1, 32'h34, 32'hFFFF0000);
      do_req(1'b1, 1'b0, 32'h34, 32'h0, 1'b0, '0, '0);
      do_req(1'b1, 1'b0, 32'h30, 32'h0, 1'b0, '0, '0);

      // reset during a store's ACCESS aborts it
      do_req(1'b0, 1'b1, 32'h20, 32'h11, 1'b0, '0, '0);
      start = 1'b1; MemRead = 1'b0; MemWrite = 1'b1; ALU_Result = 32'h20; Write_data = 32'h55;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check_eq("abort_busy_before", 32'(busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      m_rd = '0;
      check_eq("abort_busy", 32'(busy), 32'd0);
      check_eq("abort_done", 32'(done), 32'd0);
      check_eq("abort_rdata", Read_data, 32'd0);
      @(negedge clk);
      check_eq("abort_no_done", 32'(done), 32'd0);
      rst_n = 1'b1;
      do_req(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, '0, '0);

      // back-to-back loads, including the last word
      do_req(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, '0, '0);
      do_req(1'b1, 1'b0, 32'h3C, 32'h0, 1'b0, '0, '0);
      do_req(1'b1, 1'b0, 32'hFC, 32'h0, 1'b0, '0, '0);

      // randomized mix
      for (int k = 0; k < 150; k++) begin
         kind = $urandom_range(0, 9);
         rd   = $urandom_range(0, 1);
         wr   = !rd;
         a    = 32'($urandom_range(0, DEPTH - 1)) << 2;
         d    = $urandom;
         if (kind == 7) a = a | 32'($urandom_range(1, 3));
         if (kind == 8) a = 32'(DEPTH * 4) + ($urandom & 32'h0000_FFFC);
         if (kind == 9) begin rd = 1'b1; wr = 1'b1; end
         do_req(rd, wr, a, d, 1'b0, '0, '0);
      end

      // read back the whole RAM against the model
      for (int i = 0; i < DEPTH; i++) begin
         do_req(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, '0, '0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
